vga_timing_monitor: RTL

Receive-side checker for the VGA controller output interface: H_SYNC, V_SYNC, BLANK, CLOCK and 10-bit RGB.
- Runs in the 50 MHz system domain.
- Recovers pixel X/Y coordinates and measures line/frame timing against 640x480 parameters.
- Locks to the incoming stream, flags timing violations, and produces a per-frame pixel checksum.
- Sits beside the VGA pins, or in the testbench, to self-check pattern generators.

---
 rtl/vga_timing_monitor_if.sv | 16 +
 rtl/vga_timing_monitor.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_monitor_if.sv
// VGA pin bundle observed by vga_timing_monitor.
// The pattern generator drives it through master; the monitor samples it through slave.
interface vga_timing_monitor_if;
   logic       iVGA_CLOCK;
   logic       iVGA_H_SYNC;
   logic       iVGA_V_SYNC;
   logic       iVGA_BLANK;
   logic [9:0] iVGA_R;
   logic [9:0] iVGA_G;
   logic [9:0] iVGA_B;

   modport master (output iVGA_CLOCK, iVGA_H_SYNC, iVGA_V_SYNC, iVGA_BLANK,
                   iVGA_R, iVGA_G, iVGA_B);
   modport slave  (input  iVGA_CLOCK, iVGA_H_SYNC, iVGA_V_SYNC, iVGA_BLANK,
                   iVGA_R, iVGA_G, iVGA_B);
endinterface

// File: rtl/vga_timing_monitor.sv
// VGA receive-side timing checker: coordinate recovery, line/frame measurement, lock and frame checksum.
// Optional macro VGA_TIMING_MONITOR_ERR_CLR_EN adds iClear_error to clear the sticky oError.
//
// state   | meaning
// SEARCH  | waiting for a vertical sync fall to start measuring
// MEASURE | one frame of line length / line count checks before lock
// LOCKED  | timing verified; violations drop back to SEARCH
module vga_timing_monitor #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int H_TOTAL  = 800,
   parameter int V_TOTAL  = 525
) (
   input  logic        Clock,
   input  logic        Resetn,
`ifdef VGA_TIMING_MONITOR_ERR_CLR_EN
   input  logic        iClear_error,
`endif
   vga_timing_monitor_if.slave vga,
   output logic [9:0]  oCoord_X,
   output logic [9:0]  oCoord_Y,
   output logic        oPixel_valid,
   output logic        oLocked,
   output logic        oFrame_done,
   output logic [10:0] oLine_len,
   output logic [9:0]  oFrame_lines,
   output logic [15:0] oChecksum,
   output logic        oError
);

   localparam logic [10:0] H_ACT_W = 11'(H_ACTIVE);
   localparam logic [10:0] H_TOT_W = 11'(H_TOTAL);
   localparam logic [9:0]  V_ACT_W = 10'(V_ACTIVE);
   localparam logic [9:0]  V_TOT_W = 10'(V_TOTAL);
   localparam logic [10:0] H_MAX   = 11'h7FF;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t      state, state_next;
   logic        clk_prev, hs_prev, vs_prev;
   logic [10:0] h_cnt, x_cnt, line_len;
   logic [9:0]  v_cnt, y_cnt, v_cnt_eff, y_cnt_eff;
   logic [15:0] acc, acc_eff;
   logic        line_pix, meas_bad, meas_bad_eff;
   logic        strobe, hfall, vfall, pix;
   logic        len_bad, x_bad, v_bad, h_sat;
   logic        violation, publish, clear_err;

`ifdef VGA_TIMING_MONITOR_ERR_CLR_EN
   assign clear_err = iClear_error;
`else
   assign clear_err = 1'b0;
`endif

   // "_eff" values apply this strobe's hfall before its vfall, so a coincident pair closes the frame correctly
   always_comb begin
      strobe       = vga.iVGA_CLOCK & ~clk_prev;
      hfall        = strobe & ~vga.iVGA_H_SYNC & hs_prev;
      vfall        = strobe & ~vga.iVGA_V_SYNC & vs_prev;
      pix          = strobe & vga.iVGA_BLANK;
      line_len     = (h_cnt == H_MAX) ? H_MAX : h_cnt + 11'd1;
      v_cnt_eff    = hfall ? v_cnt + 10'd1 : v_cnt;
      y_cnt_eff    = (hfall && line_pix) ? y_cnt + 10'd1 : y_cnt;
      acc_eff      = pix ? acc + {6'd0, vga.iVGA_R ^ vga.iVGA_G ^ vga.iVGA_B} : acc;
      len_bad      = hfall && (line_len != H_TOT_W);
      x_bad        = hfall && line_pix && (x_cnt != H_ACT_W);
      v_bad        = vfall && ((v_cnt_eff != V_TOT_W) || (y_cnt_eff != V_ACT_W));
      h_sat        = strobe && !hfall && (h_cnt == H_MAX - 11'd1);
      meas_bad_eff = meas_bad | len_bad;
   end

   always_comb begin
      state_next = state;
      violation  = 1'b0;
      publish    = 1'b0;
      case (state)
         SEARCH: begin
            if (vfall) state_next = MEASURE;
         end
         MEASURE: begin
            if (vfall && !meas_bad_eff && (v_cnt_eff == V_TOT_W)) state_next = LOCKED;
         end
         LOCKED: begin
            if (len_bad || x_bad || v_bad || h_sat) begin
               violation  = 1'b1;
               state_next = SEARCH;
            end else if (vfall) begin
               publish = 1'b1;
            end
         end
         default: state_next = SEARCH;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) state <= SEARCH;
      else         state <= state_next;
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         clk_prev     <= 1'b0;
         hs_prev      <= 1'b1;
         vs_prev      <= 1'b1;
         h_cnt        <= '0;
         x_cnt        <= '0;
         v_cnt        <= '0;
         y_cnt        <= '0;
         acc          <= '0;
         line_pix     <= 1'b0;
         meas_bad     <= 1'b0;
         oCoord_X     <= '0;
         oCoord_Y     <= '0;
         oPixel_valid <= 1'b0;
         oLocked      <= 1'b0;
         oFrame_done  <= 1'b0;
         oLine_len    <= '0;
         oFrame_lines <= '0;
         oChecksum    <= '0;
         oError       <= 1'b0;
      end else begin
         clk_prev     <= vga.iVGA_CLOCK;
         oPixel_valid <= pix;
         oFrame_done  <= publish;
         oLocked      <= (state_next == LOCKED);
         if (violation)      oError <= 1'b1;
         else if (clear_err) oError <= 1'b0;
         if (strobe) begin
            hs_prev  <= vga.iVGA_H_SYNC;
            vs_prev  <= vga.iVGA_V_SYNC;
            acc      <= vfall ? 16'd0 : acc_eff;
            meas_bad <= vfall ? 1'b0 : meas_bad_eff;
            line_pix <= hfall ? pix : (line_pix | pix);
            if (hfall) begin
               h_cnt     <= '0;
               oLine_len <= line_len;
               x_cnt     <= pix ? 11'd1 : 11'd0;
            end else begin
               if (h_cnt != H_MAX) h_cnt <= h_cnt + 11'd1;
               if (pix && (x_cnt != H_MAX)) x_cnt <= x_cnt + 11'd1;
            end
            if (pix) begin
               oCoord_X <= hfall ? 10'd0 : x_cnt[9:0];
               oCoord_Y <= y_cnt_eff;
            end
            if (vfall) begin
               oFrame_lines <= v_cnt_eff;
               v_cnt        <= '0;
               y_cnt        <= '0;
            end else begin
               v_cnt <= v_cnt_eff;
               y_cnt <= y_cnt_eff;
            end
            if (publish) oChecksum <= acc_eff;
         end
      end
   end

endmodule
